// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port for imem_loader.
// A byte moves on a rising clock edge where rx_valid && rx_ready. The source may
// raise rx_valid at any time and holds rx_data stable until that edge. rx_ready
// never depends on rx_valid. mem_we is a single-cycle write strobe that qualifies
// mem_waddr and mem_wdata.
interface imem_loader_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 8
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/XOR-checksum byte frame and writes the
// payload words into instruction memory, holding the CPU until a good load.
module imem_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        load_req,
  imem_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] word_cnt,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [15:0] DEPTH_N = 16'(DEPTH);

  state_t           state, state_nx;
  logic [7:0]       csum;
  logic [1:0]       lane;
  logic [AW-1:0]    word_idx;
  logic [23:0]      lo_bytes;
  logic             fire;
  logic             start;
  logic             last_word;
  logic [15:0]      len_full;
  logic [WIDTH-1:0] word_next;

  assign fire      = bus.rx_valid && bus.rx_ready;
  assign start     = load_req && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign len_full  = {bus.rx_data, word_cnt[7:0]};
  assign last_word = ({{(16-AW){1'b0}}, word_idx} == (word_cnt - 16'd1));
  assign word_next = {bus.rx_data, lo_bytes};

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_LEN0;
      S_LEN0: if (fire) state_nx = S_LEN1;
      S_LEN1: if (fire) begin
        if (len_full > DEPTH_N)      state_nx = S_ERR;
        else if (len_full == 16'd0)  state_nx = S_CSUM;
        else                         state_nx = S_DATA;
      end
      S_DATA: if (fire && lane == 2'd3 && last_word) state_nx = S_CSUM;
      S_CSUM: if (fire) state_nx = (bus.rx_data == csum) ? S_DONE : S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs are pure decodes of the state flop, so they change one
  // cycle after the byte that caused the transition.
  always_comb begin
    bus.rx_ready = (state == S_LEN0) || (state == S_LEN1) ||
                   (state == S_DATA) || (state == S_CSUM);
    cpu_hold     = (state != S_DONE);
    load_done    = (state == S_DONE);
    load_err     = (state == S_ERR);
    dbg_state    = state;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      csum          <= '0;
      lane          <= '0;
      word_idx      <= '0;
      lo_bytes      <= '0;
      word_cnt      <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (start) begin
        csum     <= '0;
        lane     <= '0;
        word_idx <= '0;
      end
      if (fire) begin
        case (state)
          S_LEN0: begin
            word_cnt[7:0] <= bus.rx_data;
            csum          <= csum ^ bus.rx_data;
          end
          S_LEN1: begin
            word_cnt[15:8] <= bus.rx_data;
            csum           <= csum ^ bus.rx_data;
          end
          S_DATA: begin
            csum <= csum ^ bus.rx_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: lo_bytes[7:0]   <= bus.rx_data;
              2'd1: lo_bytes[15:8]  <= bus.rx_data;
              2'd2: lo_bytes[23:16] <= bus.rx_data;
              default: begin
                bus.mem_we    <= 1'b1;
                bus.mem_waddr <= word_idx;
                bus.mem_wdata <= word_next;
                word_idx      <= word_idx + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame bench for imem_loader: a frame-level model predicts writes and
// final status; one negedge process checks every memory write against it.
module tb_imem_loader;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        arstn;
  logic        load_req;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] word_cnt;
  logic [2:0]  dbg_state;

  imem_loader_if #(.WIDTH(32), .AW(8)) bus ();

  imem_loader #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .load_req  (load_req),
    .bus       (bus.slave),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .word_cnt  (word_cnt),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];
  logic [39:0] wlog[$];
  logic [31:0] words[$];
  logic [7:0]  last_csum;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next predicted {addr, data}.
  always @(negedge clk) begin
    if (arstn === 1'b1 && bus.mem_we === 1'b1) begin
      wlog.push_back({bus.mem_waddr, bus.mem_wdata});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %h expected none", {bus.mem_waddr, bus.mem_wdata});
      end else begin
        check("mem_write", {bus.mem_waddr, bus.mem_wdata}, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: got rx_ready=%b expected 1 within 64 cycles", bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap(input bit pulse_req);
    int k = $urandom_range(1, 3);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    for (int i = 0; i < k; i++) begin
      load_req = pulse_req && (i == 0);
      @(negedge clk);
    end
    load_req = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) gap(1'($urandom_range(0, 1)));
    send_byte(b);
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic run_frame(input int n, input logic [7:0] csum_xor, input bit gaps);
    logic [15:0] nn;
    logic [7:0]  cs;
    logic [31:0] w;
    bit          ok;
    nn = n[15:0];
    cs = nn[7:0] ^ nn[15:8];
    // load_req and the first byte presented together: the byte waits one cycle.
    load_req     = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = nn[7:0];
    @(negedge clk);
    load_req = 1'b0;
    check("hold_after_req", cpu_hold, 1);
    check("done_cleared", load_done, 0);
    check("err_cleared", load_err, 0);
    check("ready_in_len0", bus.rx_ready, 1);
    send_byte(nn[7:0]);
    send_b(nn[15:8], gaps);
    if (n > DEPTH) begin
      check("ovf_err", load_err, 1);
      check("ovf_ready", bus.rx_ready, 0);
      check("ovf_hold", cpu_hold, 1);
      check("ovf_word_cnt", word_cnt, nn);
      repeat (4) @(negedge clk);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = words[i];
      exp_q.push_back({i[7:0], w});
      for (int j = 0; j < 4; j++) begin
        cs = cs ^ w[8*j +: 8];
        send_b(w[8*j +: 8], gaps);
      end
    end
    last_csum = cs;
    send_b(cs ^ csum_xor, gaps);
    ok = (csum_xor == 8'h00);
    check("load_done", load_done, ok);
    check("load_err", load_err, !ok);
    check("cpu_hold", cpu_hold, !ok);
    check("ready_after", bus.rx_ready, 0);
    check("word_cnt", word_cnt, nn);
    check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hold"}, cpu_hold, 1);
    check({tag, "_ready"}, bus.rx_ready, 0);
    check({tag, "_we"}, bus.mem_we, 0);
    check({tag, "_waddr"}, bus.mem_waddr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_err"}, load_err, 0);
    check({tag, "_word_cnt"}, word_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w0;
    arstn        = 1'b0;
    load_req     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    arstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", bus.rx_ready, 0);

    // Known two-word program; checksum and writes pinned by hand.
    words.delete();
    words.push_back(32'h00200613);
    words.push_back(32'h00300693);
    wlog.delete();
    run_frame(2, 8'h00, 1'b0);
    check("pin_csum", last_csum, 8'h92);
    check("pin_write0", wlog.size() > 0 ? wlog[0] : 40'hx, {8'h00, 32'h00200613});
    check("pin_write1", wlog.size() > 1 ? wlog[1] : 40'hx, {8'h01, 32'h00300693});

    run_frame(2, 8'h01, 1'b0);
    run_frame(DEPTH + 1, 8'h00, 1'b0);
    run_frame(0, 8'h00, 1'b0);
    run_frame(0, 8'h55, 1'b0);

    // Same random words gapless, then with gaps and ignored mid-frame load_req.
    for (int r = 0; r < 3; r++) begin
      fill_words($urandom_range(1, 8));
      run_frame(words.size(), 8'h00, 1'b0);
      run_frame(words.size(), 8'h00, 1'b1);
    end

    fill_words(DEPTH);
    wlog.delete();
    run_frame(DEPTH, 8'h00, 1'b0);
    check("full_last_addr", wlog.size() == DEPTH ? wlog[DEPTH-1][39:32] : 40'hx, 255);

    // Reset after 6 payload bytes: only word 0 completes.
    fill_words(4);
    w0 = words[0];
    exp_q.push_back({8'h00, w0});
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    send_byte(8'h04);
    send_byte(8'h00);
    for (int j = 0; j < 6; j++) send_byte(j < 4 ? w0[8*j +: 8] : words[1][8*(j-4) +: 8]);
    arstn = 1'b0;
    #1;
    check_reset_values("midreset");
    check("midreset_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    fill_words(3);
    run_frame(3, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
